// File: rtl/xc_aessub_lanes.sv
// xc_aessub_sbox: one AES S-box lane, forward (enc=1) or inverse (enc=0).
// Latency: combinational.
// Backpressure: none; output follows the input byte.
// Ports: enc selects direction, din is the byte in, dout the substituted byte.
module xc_aessub_sbox (
    input  logic       enc,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; it maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    logic [7:0] inv_affine;
    logic [7:0] inv_in;
    logic [7:0] inv_out;
    logic [7:0] fwd_out;

    // Both directions share one field inverter: forward applies the affine
    // map after inversion, inverse undoes the affine map before it.
    always_comb begin
        inv_affine = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
        inv_in     = enc ? din : inv_affine;
        inv_out    = gf_inv(inv_in);
        fwd_out    = inv_out ^ rotl(inv_out, 1) ^ rotl(inv_out, 2)
                   ^ rotl(inv_out, 3) ^ rotl(inv_out, 4) ^ 8'h63;
        dout       = enc ? fwd_out : inv_out;
    end

endmodule

// xc_aessub_lanes: AES SubBytes/SubWord unit built from LANES S-boxes (1, 2 or 4).
// Latency: 4/LANES cycles per word; LANES=4 is combinational with ready=valid.
// Backpressure: none; requester holds valid and operands stable until ready pulses.
// Ports: clock, reset (sync, active-high); flush/flush_data abort and reload the
//   byte registers; valid, rs1, rs2, enc, rot, full form the request; ready
//   pulses one cycle with result, which is forced to zero otherwise.
module xc_aessub_lanes #(
    parameter int LANES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    input  logic        full,
    output logic        ready,
    output logic [31:0] result
);

    localparam int NSTEP = 4 / LANES;
    localparam int NREG  = 4 - LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("xc_aessub_lanes: LANES must be 1, 2 or 4");
    end

    logic [3:0][7:0]       src;
    logic [LANES-1:0][7:0] sb_in;
    logic [LANES-1:0][7:0] sb_out;
    logic [3:0][7:0]       word;

    // Lightweight mode interleaves the two sources; SubWord takes rs1 whole.
    always_comb begin
        if (full) src = rs1;
        else      src = {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};
    end

    // Bytes of rs2 that only SubWord-less selection would ignore.
    logic unused_rs2;
    assign unused_rs2 = ^{rs2[23:16], rs2[7:0]};

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        xc_aessub_sbox u_sbox (
            .enc  (enc),
            .din  (sb_in[j]),
            .dout (sb_out[j])
        );
    end

    if (LANES == 4) begin : g_comb
        // All four bytes in one cycle: no state, flush is irrelevant.
        assign sb_in = src & {32{valid}};
        assign word  = sb_out;
        assign ready = valid;

        logic unused_ctl;
        assign unused_ctl = ^{clock, reset, flush, flush_data};
    end else begin : g_seq
        localparam int SW = $clog2(NSTEP);

        logic [SW-1:0] step;
        logic [SW-1:0] step_nxt;
        logic          last;
        logic [7:0]    byte_q [NREG];

        assign last = (step == SW'(NSTEP - 1));

        // Step k feeds bytes LANES*k .. LANES*k+LANES-1 to the lanes.
        always_comb begin
            sb_in = '0;
            for (int k = 0; k < NSTEP; k++) begin
                if (step == SW'(k)) begin
                    for (int j = 0; j < LANES; j++) begin
                        sb_in[j] = src[LANES*k + j] & {8{valid}};
                    end
                end
            end
        end

        // Any step without valid (or a flush) restarts at step 0, so a
        // dropped request never resumes half way through.
        always_comb begin
            step_nxt = '0;
            if (valid && !flush && !last) step_nxt = step + SW'(1);
        end

        always_ff @(posedge clock) begin
            if (reset) step <= '0;
            else       step <= step_nxt;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < NREG; i++) byte_q[i] <= 8'h00;
            end else if (flush) begin
                for (int i = 0; i < NREG; i++) byte_q[i] <= flush_data[8*i +: 8];
            end else if (valid && !last) begin
                for (int i = 0; i < NREG; i++) begin
                    if (step == SW'(i / LANES)) byte_q[i] <= sb_out[i % LANES];
                end
            end
        end

        // Earlier bytes come from the registers, the final step's bytes
        // straight from the S-boxes.
        always_comb begin
            word = '0;
            for (int i = 0; i < NREG; i++)  word[i] = byte_q[i];
            for (int i = NREG; i < 4; i++) word[i] = sb_out[i - NREG];
        end

        assign ready = valid && last && !flush && !reset;

        logic unused_fd;
        assign unused_fd = ^flush_data[31:8*NREG];
    end

    assign result = !ready ? 32'h0
                  : (rot ? {word[2], word[1], word[0], word[3]} : word);

endmodule
